// File: rtl/demux_1x4_buffered.sv
// demux_1x4_buffered: routes one valid/ready input stream to one of four
// output channels (A, B, C, D), each backed by its own 2-entry FIFO. A
// stalled channel only blocks input that targets that channel.
// Channel index is {sel_2, sel_1}: 0=A, 1=B, 2=C, 3=D.
// Optional feature: define DEMUX4_STATS_EN to add the 64-bit xfer_count
// output. It holds four 16-bit wrapping push counters, one per channel.

module demux_1x4_buffered #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel_1,
    input  logic             sel_2,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             valid_a,
    output logic             valid_b,
    output logic             valid_c,
    output logic             valid_d,
    input  logic             ready_a,
    input  logic             ready_b,
    input  logic             ready_c,
    input  logic             ready_d
`ifdef DEMUX4_STATS_EN
    ,
    output logic [63:0]      xfer_count
`endif
);

    localparam int NCH = 4;

    logic [1:0]       sel_idx;
    logic [WIDTH-1:0] fifo_mem [NCH][2];
    logic [NCH-1:0]   wr_ptr;
    logic [NCH-1:0]   rd_ptr;
    logic [1:0]       count    [NCH];
    logic [NCH-1:0]   ch_ready;
    logic [NCH-1:0]   ch_valid;
    logic [NCH-1:0]   push_en;
    logic [NCH-1:0]   pop_en;
    logic [WIDTH-1:0] head     [NCH];

    assign sel_idx  = {sel_2, sel_1};
    assign ch_ready = {ready_d, ready_c, ready_b, ready_a};

    // Input acceptance depends only on the select lines and the selected
    // channel's fill level. Consumer ready never feeds in_ready, so a full
    // channel refuses input even while it is being drained.
    always_comb begin
        in_ready = rst_n && (count[sel_idx] != 2'd2);
    end

    // Per-channel push/pop strobes; a pop needs a non-empty FIFO, so ready
    // from an idle consumer has no effect.
    always_comb begin
        ch_valid = '0;
        pop_en   = '0;
        push_en  = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_valid[i] = (count[i] != 2'd0);
            pop_en[i]   = ch_valid[i] && ch_ready[i];
            push_en[i]  = in_valid && in_ready && (sel_idx == i[1:0]);
        end
    end

    // FIFO storage, pointers and fill counts. Reset wipes every entry, so any
    // data in flight when reset arrives is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < NCH; i++) begin
                count[i]       <= 2'd0;
                fifo_mem[i][0] <= '0;
                fifo_mem[i][1] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push_en[i]) begin
                    fifo_mem[i][wr_ptr[i]] <= in_data;
                    wr_ptr[i]              <= ~wr_ptr[i];
                end
                if (pop_en[i]) begin
                    rd_ptr[i] <= ~rd_ptr[i];
                end
                case ({push_en[i], pop_en[i]})
                    2'b10:   count[i] <= count[i] + 2'd1;
                    2'b01:   count[i] <= count[i] - 2'd1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Head-of-queue view for each channel; an empty channel shows zeros.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            head[i] = '0;
            if (ch_valid[i]) begin
                head[i] = fifo_mem[i][rd_ptr[i]];
            end
        end
    end

    assign out_a   = head[0];
    assign out_b   = head[1];
    assign out_c   = head[2];
    assign out_d   = head[3];
    assign valid_a = ch_valid[0];
    assign valid_b = ch_valid[1];
    assign valid_c = ch_valid[2];
    assign valid_d = ch_valid[3];

`ifdef DEMUX4_STATS_EN
    logic [15:0] stat_cnt [NCH];

    // Per-channel accepted-word counters that wrap at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                stat_cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push_en[i]) begin
                    stat_cnt[i] <= stat_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign xfer_count = {stat_cnt[3], stat_cnt[2], stat_cnt[1], stat_cnt[0]};
`else
    // Without statistics the datapath above is the whole block.
`endif

endmodule

// File: tb/tb_demux_1x4_buffered.sv
// tb_demux_1x4_buffered: directed vector table plus randomized traffic
// compared against a queue-based reference model of the four channels.
// The DEMUX4_STATS_EN counter checks are built when that macro is defined.

module tb_demux_1x4_buffered;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sel_1;
    logic             sel_2;
    logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
    logic             valid_a, valid_b, valid_c, valid_d;
    logic             ready_a, ready_b, ready_c, ready_d;
`ifdef DEMUX4_STATS_EN
    logic [63:0]      xfer_count;
`endif

    demux_1x4_buffered #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel_1    (sel_1),
        .sel_2    (sel_2),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_d    (out_d),
        .valid_a  (valid_a),
        .valid_b  (valid_b),
        .valid_c  (valid_c),
        .valid_d  (valid_d),
        .ready_a  (ready_a),
        .ready_b  (ready_b),
        .ready_c  (ready_c),
        .ready_d  (ready_d)
`ifdef DEMUX4_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        in_valid;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  ready;
        logic        exp_in_ready;
        logic [3:0]  exp_valid;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int passes = 0;

    logic [7:0]  model_q [4][$];
    logic [15:0] model_cnt [4];

    // Add one directed row: inputs for the cycle and the outputs expected
    // before that cycle's edge. Valid and data are packed {D, C, B, A}.
    function automatic void tv(input logic r, input logic iv, input logic [1:0] s,
                               input logic [7:0] d, input logic [3:0] rdy,
                               input logic ir, input logic [3:0] v, input logic [31:0] o);
        vec_t t;
        t.rst_n = r; t.in_valid = iv; t.sel = s; t.data = d; t.ready = rdy;
        t.exp_in_ready = ir; t.exp_valid = v; t.exp_out = o;
        vecs.push_back(t);
    endfunction

    task automatic apply_stimulus(input logic r, input logic iv, input logic [1:0] s,
                                  input logic [7:0] d, input logic [3:0] rdy);
        rst_n    = r;
        in_valid = iv;
        {sel_2, sel_1} = s;
        in_data  = d;
        {ready_d, ready_c, ready_b, ready_a} = rdy;
    endtask

    task automatic check_field(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_output(input string tag, input logic ir, input logic [3:0] v,
                                input logic [31:0] o);
        check_field({tag, " in_ready"}, 64'(in_ready), 64'(ir));
        check_field({tag, " valid"}, 64'({valid_d, valid_c, valid_b, valid_a}), 64'(v));
        check_field({tag, " out_a"}, 64'(out_a), 64'(o[7:0]));
        check_field({tag, " out_b"}, 64'(out_b), 64'(o[15:8]));
        check_field({tag, " out_c"}, 64'(out_c), 64'(o[23:16]));
        check_field({tag, " out_d"}, 64'(out_d), 64'(o[31:24]));
    endtask

    function automatic logic model_in_ready();
        return rst_n && (model_q[{sel_2, sel_1}].size() < 2);
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v = '0;
        for (int i = 0; i < 4; i++) v[i] = (model_q[i].size() != 0);
        return v;
    endfunction

    function automatic logic [31:0] model_out();
        logic [31:0] o = '0;
        for (int i = 0; i < 4; i++)
            if (model_q[i].size() != 0) o[i*8 +: 8] = model_q[i][0];
        return o;
    endfunction

    // Advance the reference model by one clock edge using the current inputs.
    task automatic model_edge();
        logic       acc;
        logic [3:0] rdy;
        logic [3:0] v;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                model_q[i].delete();
                model_cnt[i] = 16'd0;
            end
        end else begin
            acc = in_valid && model_in_ready();
            rdy = {ready_d, ready_c, ready_b, ready_a};
            v   = model_valid();
            for (int i = 0; i < 4; i++)
                if (v[i] && rdy[i]) void'(model_q[i].pop_front());
            if (acc) begin
                model_q[{sel_2, sel_1}].push_back(in_data);
                model_cnt[{sel_2, sel_1}] = model_cnt[{sel_2, sel_1}] + 16'd1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic       held;
        logic       riv;
        logic [1:0] rsel;
        logic [7:0] rdata;
        logic [3:0] rdy;
        logic       rr;

        for (int i = 0; i < 4; i++) model_cnt[i] = 16'd0;

        // Reset held with in_valid high, then release and walk the corner cases.
        tv(0,1,0,8'h99,4'hF, 0,4'b0000,32'h0);
        tv(0,1,0,8'h99,4'hF, 0,4'b0000,32'h0);
        tv(0,1,0,8'h99,4'hF, 0,4'b0000,32'h0);
        tv(1,0,0,8'h00,4'hF, 1,4'b0000,32'h0);
        tv(1,0,1,8'h00,4'hF, 1,4'b0000,32'h0);
        tv(1,0,2,8'h00,4'hF, 1,4'b0000,32'h0);
        tv(1,0,3,8'h00,4'hF, 1,4'b0000,32'h0);
        // Routing to all four channels
        tv(1,1,0,8'h11,4'hF, 1,4'b0000,32'h0);
        tv(1,1,1,8'h22,4'hF, 1,4'b0001,32'h0000_0011);
        tv(1,1,2,8'h33,4'hF, 1,4'b0010,32'h0000_2200);
        tv(1,1,3,8'h44,4'hF, 1,4'b0100,32'h0033_0000);
        tv(1,0,0,8'h00,4'hF, 1,4'b1000,32'h4400_0000);
        tv(1,0,0,8'h00,4'hF, 1,4'b0000,32'h0);
        // Backpressure on B and isolation of C
        tv(1,1,1,8'hA1,4'hD, 1,4'b0000,32'h0);
        tv(1,1,1,8'hA2,4'hD, 1,4'b0010,32'h0000_A100);
        tv(1,1,1,8'hA3,4'hD, 0,4'b0010,32'h0000_A100);
        tv(1,1,1,8'hA3,4'hD, 0,4'b0010,32'h0000_A100);
        tv(1,1,2,8'hC1,4'hD, 1,4'b0010,32'h0000_A100);
        tv(1,0,1,8'h00,4'hD, 0,4'b0110,32'h00C1_A100);
        tv(1,1,1,8'hA3,4'hF, 0,4'b0010,32'h0000_A100);
        tv(1,1,1,8'hA3,4'hF, 1,4'b0010,32'h0000_A200);
        tv(1,0,0,8'h00,4'hF, 1,4'b0010,32'h0000_A300);
        tv(1,0,0,8'h00,4'hF, 1,4'b0000,32'h0);
        // Simultaneous push and pop on A with one word held
        tv(1,1,0,8'h55,4'h0, 1,4'b0000,32'h0);
        tv(1,1,0,8'h66,4'h1, 1,4'b0001,32'h0000_0055);
        tv(1,0,0,8'h00,4'h0, 1,4'b0001,32'h0000_0066);
        tv(1,0,0,8'h00,4'h1, 1,4'b0001,32'h0000_0066);
        tv(1,0,0,8'h00,4'hF, 1,4'b0000,32'h0);
        // Fill B and D, reset mid-stream, then restart D
        tv(1,1,1,8'hB1,4'h0, 1,4'b0000,32'h0);
        tv(1,1,1,8'hB2,4'h0, 1,4'b0010,32'h0000_B100);
        tv(1,1,3,8'hD1,4'h0, 1,4'b0010,32'h0000_B100);
        tv(1,1,3,8'hD2,4'h0, 1,4'b1010,32'hD100_B100);
        tv(0,1,3,8'hD3,4'h0, 0,4'b1010,32'hD100_B100);
        tv(1,1,3,8'hE1,4'h0, 1,4'b0000,32'h0);
        tv(1,1,3,8'hE2,4'h0, 1,4'b1000,32'hE100_0000);
        tv(1,0,3,8'h00,4'h0, 0,4'b1000,32'hE100_0000);
        tv(1,0,3,8'h00,4'hF, 0,4'b1000,32'hE100_0000);
        tv(1,0,3,8'h00,4'hF, 1,4'b1000,32'hE200_0000);
        tv(1,0,3,8'h00,4'hF, 1,4'b0000,32'h0);

        // First reset edge; outputs before it are undefined.
        apply_stimulus(0, 1, 2'd0, 8'h99, 4'hF);
        tick();

        for (int n = 0; n < vecs.size(); n++) begin
            apply_stimulus(vecs[n].rst_n, vecs[n].in_valid, vecs[n].sel, vecs[n].data, vecs[n].ready);
            @(negedge clk);
            check_output($sformatf("tbl[%0d]", n), vecs[n].exp_in_ready, vecs[n].exp_valid, vecs[n].exp_out);
            tick();
        end

        // Randomized traffic; a refused word keeps its select and data.
        held = 1'b0; riv = 1'b0; rsel = 2'd0; rdata = 8'd0;
        for (int n = 0; n < 3000; n++) begin
            rr = ($urandom_range(0, 99) != 0);
            if (!held) begin
                riv   = ($urandom_range(0, 2) != 0);
                rsel  = 2'($urandom_range(0, 3));
                rdata = 8'($urandom_range(0, 255));
            end
            for (int i = 0; i < 4; i++) rdy[i] = ($urandom_range(0, 9) < 6);
            apply_stimulus(rr, riv, rsel, rdata, rdy);
            @(negedge clk);
            check_output($sformatf("rnd[%0d]", n), model_in_ready(), model_valid(), model_out());
`ifdef DEMUX4_STATS_EN
            check_field($sformatf("rnd[%0d] xfer_count", n), xfer_count,
                        {model_cnt[3], model_cnt[2], model_cnt[1], model_cnt[0]});
`endif
            held = riv && !model_in_ready();
            tick();
        end

`ifdef DEMUX4_STATS_EN
        // Counter wrap on C, then clear on reset.
        apply_stimulus(0, 0, 2'd0, 8'h00, 4'hF);
        tick();
        for (int n = 0; n < 16'hFFFE; n++) begin
            apply_stimulus(1, 1, 2'd2, 8'(n), 4'hF);
            tick();
        end
        apply_stimulus(1, 0, 2'd2, 8'h00, 4'hF);
        @(negedge clk);
        check_field("stats C preload", 64'(xfer_count[47:32]), 64'h0000_FFFE);
        tick();
        for (int n = 0; n < 2; n++) begin
            apply_stimulus(1, 1, 2'd2, 8'h5A, 4'hF);
            tick();
        end
        apply_stimulus(1, 0, 2'd2, 8'h00, 4'hF);
        @(negedge clk);
        check_field("stats wrap", xfer_count, 64'h0);
        tick();
        apply_stimulus(1, 1, 2'd0, 8'h01, 4'hF);
        tick();
        apply_stimulus(0, 0, 2'd0, 8'h00, 4'hF);
        @(negedge clk);
        check_field("stats A count", xfer_count, 64'h1);
        tick();
        @(negedge clk);
        check_field("stats reset", xfer_count, 64'h0);
`endif

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/demux_1x4_buffered.md
# demux_1x4_buffered

Buffered 1-to-4 demultiplexer: the counterpart of the team's 4-to-1 mux, routing one valid/ready input stream to one of four output channels (A, B, C, D). Each channel holds a 2-entry FIFO, so a stalled channel never blocks the input when traffic targets a different channel. Channel selection uses the same two-select encoding as the mux. The block sits between a single producer and four independent consumers.

## Interface
- `WIDTH`, default 8, data width of input and every channel.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous active-low reset.
- `in_data`  input  WIDTH  input word.
- `in_valid`  input  1  input word present.
- `in_ready`  output  1  block accepts the word this cycle.
- `sel_1`  input  1  low select bit: A/B or C/D.
- `sel_2`  input  1  high select bit: pair select. Channel index is {sel_2, sel_1}: 0=A, 1=B, 2=C, 3=D.
- `out_a`, `out_b`, `out_c`, `out_d`  output  WIDTH each  head entry of each channel FIFO.
- `valid_a`, `valid_b`, `valid_c`, `valid_d`  output  1 each  channel FIFO non-empty.
- `ready_a`, `ready_b`, `ready_c`, `ready_d`  input  1 each  consumer takes the head entry.

## Operation
- Each channel has a 2-entry FIFO with these state elements:
  - 2 data registers
  - 1-bit write pointer
  - 1-bit read pointer
  - 2-bit count (0, 1 or 2)
- `in_ready` = `rst_n` AND (count[sel] != 2). It is combinational from the select inputs and registered state only, with no path from the `ready_*` inputs.
- Push: when `in_valid` AND `in_ready` are high at a rising edge:
  - `in_data` is written to the selected channel at its write pointer;
  - the write pointer toggles;
  - the count increments.
- Pop on channel i: when `valid_i` AND `ready_i` are high at a rising edge, the read pointer toggles and the count decrements.
- `ready_i` while `valid_i` is low is ignored.
- Simultaneous push and pop on the same channel with count 1: the count stays 1 and both pointers toggle.
- Push and pop on different channels in the same cycle are independent.
- A full channel refuses input. There is no pass-through, even if its consumer pops in that same cycle.
- `valid_i` = (count_i != 0).
- `out_i` shows the entry at the read pointer when non-empty, and drives all zeros when empty.
- Producer rule: `sel_1`, `sel_2` and `in_data` are held stable while `in_valid` is high and `in_ready` is low. The block does not check this rule.
- Ordering: words to the same channel leave in acceptance order. There is no ordering guarantee across channels.

## Timing
- Reset (`rst_n` low at a rising edge):
  - all counts and pointers go to 0 and all data registers are cleared;
  - after that edge, `valid_*` = 0 and `out_*` = 0;
  - `in_ready` = 0 for as long as `rst_n` is low, so no push can occur;
  - in-flight data is discarded, including when reset is asserted mid-stream.
- First cycle with `rst_n` high: `in_ready` = 1 for every select value.
- Latency: a word accepted at edge N appears on `out_i` with `valid_i` = 1 after edge N, that is, 1 cycle.
- Throughput: 1 word/cycle into any channel whose consumer holds `ready` high continuously.
- Fill behaviour: a channel with a stalled consumer accepts exactly 2 words, then `in_ready` drops while that channel is selected.
- Drain behaviour: after one pop from a full channel, `in_ready` for that channel returns high in the following cycle.

## Configuration
- Macro: `DEMUX4_STATS_EN`.
- When defined:
  - adds output `xfer_count`, 64 bits wide: four 16-bit counters, [15:0]=A, [31:16]=B, [47:32]=C, [63:48]=D;
  - each counter increments on every push to its channel and wraps from 0xFFFF to 0x0000;
  - all counters clear on reset.
- When not defined: the port and the counters are absent, and datapath behaviour is identical.

## Test plan
- Reset checks:
  - Hold `rst_n`=0 with `in_valid`=1 for 3 cycles -> `in_ready`=0, all `valid_*`=0, all `out_*`=0.
  - Release `rst_n` -> `in_ready`=1.
- Routing, with all `ready_*`=1: push 0x11, 0x22, 0x33, 0x44 with sel {0,0}, {0,1}, {1,0}, {1,1} on consecutive cycles -> each word appears one cycle later on `out_a`, `out_b`, `out_c`, `out_d` respectively, with exactly one `valid` pulse per channel.
- Backpressure and isolation:
  - Set `ready_b`=0 and push 0xA1, 0xA2, 0xA3 to B -> `in_ready` drops after the second accept, and `valid_b`=1 with `out_b`=0xA1.
  - Switch select to C -> the push is accepted immediately.
  - Raise `ready_b` -> B outputs 0xA1 then 0xA2, after which 0xA3 is accepted.
- Concurrent push and pop: channel A holds one word 0x55 and `ready_a`=1; push 0x66 to A in the same cycle -> count stays 1, and `out_a`=0x66 next cycle.
- Mid-stream reset: assert reset with B and D full -> all FIFOs are empty on the next cycle, and subsequent traffic restarts from pointer 0.
- Statistics, with `DEMUX4_STATS_EN` defined:
  - Preload C's counter to 0xFFFE via 0xFFFE pushes, then push 2 more -> `xfer_count[47:32]`=0x0000, with the other counters unchanged.
  - Assert reset -> `xfer_count` = 0.
